// File: rtl/conv2d_if.sv
// Bus between the convolution engine and its sequencer/memory pool:
// the layer handshake, two read ports and one result write port.
interface conv2d_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic                     start;
  logic                     relu_en;
  logic        [ADDR_W-1:0] pix_base_addr;
  logic        [ADDR_W-1:0] kernel_base_addr;
  logic        [ADDR_W-1:0] result_base_addr;
  logic                     pix_rd_en;
  logic        [ADDR_W-1:0] pix_addr;
  logic signed [DATA_W-1:0] pix_data;
  logic                     kw_rd_en;
  logic        [ADDR_W-1:0] kw_addr;
  logic signed [DATA_W-1:0] kw_data;
  logic                     res_we;
  logic        [ADDR_W-1:0] res_addr;
  logic signed [DATA_W-1:0] res_data;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, relu_en, pix_base_addr, kernel_base_addr, result_base_addr,
    input  pix_data, kw_data,
    output pix_rd_en, pix_addr, kw_rd_en, kw_addr,
    output res_we, res_addr, res_data, busy, done
  );

  modport master (
    output start, relu_en, pix_base_addr, kernel_base_addr, result_base_addr,
    output pix_data, kw_data,
    input  pix_rd_en, pix_addr, kw_rd_en, kw_addr,
    input  res_we, res_addr, res_data, busy, done
  );
endinterface

// File: rtl/conv2d_engine.sv
// Multi-channel strided 2-D convolution: one read pair per tap, MAC on the
// returning data, then a saturated (optionally ReLU) write per output pixel.
module conv2d_engine #(
  parameter int IMG_SIZE    = 48,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 3,
  parameter int STRIDE      = 1,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 40
) (
  input  logic      clk,
  input  logic      rst_n,
  conv2d_if.slave   io
);

  localparam int OUT   = (IMG_SIZE - KERNEL_SIZE) / STRIDE + 1;
  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT - 1);

  localparam logic [31:0] P_IMG  = 32'(IMG_SIZE);
  localparam logic [31:0] P_IMG2 = 32'(IMG_SIZE * IMG_SIZE);
  localparam logic [31:0] P_K    = 32'(KERNEL_SIZE);
  localparam logic [31:0] P_K2   = 32'(KERNEL_SIZE * KERNEL_SIZE);
  localparam logic [31:0] P_S    = 32'(STRIDE);
  localparam logic [31:0] P_OUT  = 32'(OUT);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

  function automatic logic signed [DATA_W-1:0] sat_relu(
    input logic signed [ACC_W-1:0] acc,
    input logic                    relu
  );
    if (relu && acc[ACC_W-1])
      return '0;
    if (acc > SAT_MAX)
      return {1'b0, {(DATA_W-1){1'b1}}};
    if (acc < SAT_MIN)
      return {1'b1, {(DATA_W-1){1'b0}}};
    return acc[DATA_W-1:0];
  endfunction

  state_t                    r_state, w_next;
  logic                      r_relu;
  logic        [ADDR_W-1:0]  r_pix_base, r_kw_base, r_res_base;
  logic        [CNT_W-1:0]   r_row, r_col, r_c, r_ky, r_kx;
  logic                      r_vld_p1, r_first_p1;
  logic signed [ACC_W-1:0]   r_acc;

  logic                      w_first_tap, w_last_tap, w_last_pix;
  logic        [ADDR_W-1:0]  w_pix_addr, w_kw_addr, w_res_addr;
  logic signed [2*DATA_W-1:0] w_prod_p1;
  logic signed [ACC_W-1:0]   w_prod_ext_p1;

  assign w_first_tap = (r_c == '0) && (r_ky == '0) && (r_kx == '0);
  assign w_last_tap  = (r_c == C_LAST) && (r_ky == K_LAST) && (r_kx == K_LAST);
  assign w_last_pix  = (r_row == OUT_LAST) && (r_col == OUT_LAST);

  // Offsets are formed in 32 bits and truncated so every sum wraps at ADDR_W.
  assign w_pix_addr = r_pix_base + ADDR_W'(32'(r_c) * P_IMG2
                    + (32'(r_row) * P_S + 32'(r_ky)) * P_IMG
                    + 32'(r_col) * P_S + 32'(r_kx));
  assign w_kw_addr  = r_kw_base + ADDR_W'(32'(r_c) * P_K2 + 32'(r_ky) * P_K + 32'(r_kx));
  assign w_res_addr = r_res_base + ADDR_W'(32'(r_row) * P_OUT + 32'(r_col));

  assign w_prod_p1     = io.pix_data * io.kw_data;
  assign w_prod_ext_p1 = {{(ACC_W-2*DATA_W){w_prod_p1[2*DATA_W-1]}}, w_prod_p1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (io.start) w_next = S_FETCH;
      S_FETCH: if (w_last_tap) w_next = S_DRAIN;
      S_DRAIN: w_next = S_WRITE;
      S_WRITE: w_next = w_last_pix ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    io.pix_rd_en = 1'b0;
    io.kw_rd_en  = 1'b0;
    io.pix_addr  = '0;
    io.kw_addr   = '0;
    io.res_we    = 1'b0;
    io.res_addr  = '0;
    io.res_data  = '0;
    io.busy      = 1'b0;
    io.done      = 1'b0;
    case (r_state)
      S_FETCH: begin
        io.pix_rd_en = 1'b1;
        io.kw_rd_en  = 1'b1;
        io.pix_addr  = w_pix_addr;
        io.kw_addr   = w_kw_addr;
        io.busy      = 1'b1;
      end
      S_DRAIN: io.busy = 1'b1;
      S_WRITE: begin
        io.res_we   = 1'b1;
        io.res_addr = w_res_addr;
        io.res_data = sat_relu(r_acc, r_relu);
        io.busy     = 1'b1;
      end
      S_DONE:  io.done = 1'b1;
      default: ;
    endcase
  end

  // p0: tap request issued in FETCH; p1: returned read data is multiply-accumulated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_relu     <= 1'b0;
      r_pix_base <= '0;
      r_kw_base  <= '0;
      r_res_base <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_c        <= '0;
      r_ky       <= '0;
      r_kx       <= '0;
      r_vld_p1   <= 1'b0;
      r_first_p1 <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_vld_p1   <= (r_state == S_FETCH);
      r_first_p1 <= (r_state == S_FETCH) && w_first_tap;
      if (r_vld_p1)
        r_acc <= (r_first_p1 ? '0 : r_acc) + w_prod_ext_p1;

      case (r_state)
        S_IDLE: if (io.start) begin
          r_relu     <= io.relu_en;
          r_pix_base <= io.pix_base_addr;
          r_kw_base  <= io.kernel_base_addr;
          r_res_base <= io.result_base_addr;
          r_row      <= '0;
          r_col      <= '0;
          r_c        <= '0;
          r_ky       <= '0;
          r_kx       <= '0;
        end
        S_FETCH: begin
          if (r_kx != K_LAST) begin
            r_kx <= r_kx + 1'b1;
          end else begin
            r_kx <= '0;
            if (r_ky != K_LAST) begin
              r_ky <= r_ky + 1'b1;
            end else begin
              r_ky <= '0;
              r_c  <= (r_c == C_LAST) ? '0 : r_c + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (r_col != OUT_LAST) begin
            r_col <= r_col + 1'b1;
          end else begin
            r_col <= '0;
            r_row <= (r_row == OUT_LAST) ? '0 : r_row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_engine.sv
// Scoreboard bench for conv2d_engine: a reference convolution fills the expected
// write queue at each start; the monitor pops and compares every res_we.
module tb_conv2d_engine;

  localparam int IMG    = 5;
  localparam int K      = 3;
  localparam int CH     = 2;
  localparam int S      = 2;
  localparam int AW     = 14;
  localparam int DW     = 16;
  localparam int ACCW   = 40;
  localparam int OUT    = (IMG - K) / S + 1;
  localparam int TAPS   = CH * K * K;
  localparam int NPIX   = OUT * OUT;
  localparam int LAYER  = NPIX * (TAPS + 2);
  localparam int MEMSZ  = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv2d_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  conv2d_engine #(
    .IMG_SIZE(IMG), .KERNEL_SIZE(K), .CHANNELS(CH), .STRIDE(S),
    .ADDR_W(AW), .DATA_W(DW), .ACC_W(ACCW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  logic signed [DW-1:0] mem_pix [0:MEMSZ-1];
  logic signed [DW-1:0] mem_kw  [0:MEMSZ-1];

  always @(posedge clk) begin
    if (bus.pix_rd_en) bus.pix_data <= mem_pix[bus.pix_addr];
    if (bus.kw_rd_en)  bus.kw_data  <= mem_kw[bus.kw_addr];
  end

  wr_t          exp_q[$];
  wr_t          mon_e;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_writes = 0;
  int           n_done   = 0;
  logic [AW-1:0] pix_first [0:NPIX-1];
  logic [AW-1:0] kw_first  [0:NPIX-1];
  logic [AW-1:0] rd_first3 [0:2];

  always @(negedge clk) begin
    if (bus.done) n_done++;
    if (bus.res_we) begin
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 bus.res_addr, bus.res_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.res_addr !== mon_e.addr || bus.res_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL result_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.res_addr, bus.res_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic fill_mem(input logic signed [DW-1:0] pv, input logic signed [DW-1:0] kv,
                          input bit rnd);
    for (int i = 0; i < MEMSZ; i++) begin
      if (rnd) begin
        mem_pix[i] = DW'(int'($urandom_range(0, 400)) - 200);
        mem_kw[i]  = DW'(int'($urandom_range(0, 400)) - 200);
      end else begin
        mem_pix[i] = pv;
        mem_kw[i]  = kv;
      end
    end
  endtask

  task automatic push_expected(input logic [AW-1:0] pb, input logic [AW-1:0] kb,
                               input logic [AW-1:0] rb, input bit relu);
    longint        acc;
    logic [AW-1:0] pa, ka;
    wr_t           e;
    for (int r = 0; r < OUT; r++) begin
      for (int c = 0; c < OUT; c++) begin
        acc = 0;
        for (int ch = 0; ch < CH; ch++)
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++) begin
              pa  = pb + AW'(ch*IMG*IMG + (r*S + ky)*IMG + c*S + kx);
              ka  = kb + AW'(ch*K*K + ky*K + kx);
              acc += longint'(mem_pix[pa]) * longint'(mem_kw[ka]);
            end
        if (relu && acc < 0)   e.data = 16'h0000;
        else if (acc > 32767)  e.data = 16'h7FFF;
        else if (acc < -32768) e.data = 16'h8000;
        else                   e.data = acc[DW-1:0];
        e.addr = rb + AW'(r*OUT + c);
        exp_q.push_back(e);
      end
    end
  endtask

  // Starts a layer and follows it until done; returns the edge count from
  // acceptance to DONE, the number of read cycles and read/write overlaps.
  task automatic run_layer(input bit relu, input logic [AW-1:0] pb, input logic [AW-1:0] kb,
                           input logic [AW-1:0] rb, input int glitch_at,
                           output int done_edge, output int rd_cnt, output int overlap);
    push_expected(pb, kb, rb, relu);
    n_writes  = 0;
    rd_cnt    = 0;
    overlap   = 0;
    done_edge = -1;
    @(negedge clk);
    bus.relu_en          = relu;
    bus.pix_base_addr    = pb;
    bus.kernel_base_addr = kb;
    bus.result_base_addr = rb;
    bus.start            = 1'b1;
    @(posedge clk);
    #1;
    bus.start            = 1'b0;
    bus.pix_base_addr    = ~pb;
    bus.kernel_base_addr = ~kb;
    bus.result_base_addr = ~rb;
    bus.relu_en          = ~relu;
    for (int cyc = 1; cyc <= 4 * LAYER; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == glitch_at);
      if (bus.pix_rd_en) begin
        if (rd_cnt < 3) rd_first3[rd_cnt] = bus.pix_addr;
        if ((rd_cnt % TAPS) == 0 && (rd_cnt / TAPS) < NPIX) begin
          pix_first[rd_cnt / TAPS] = bus.pix_addr;
          kw_first[rd_cnt / TAPS]  = bus.kw_addr;
        end
        rd_cnt++;
      end
      if (bus.res_we && (bus.pix_rd_en || bus.kw_rd_en)) overlap++;
      if (bus.done) begin
        done_edge = cyc - 1;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.relu_en = 1'b0;
    bus.pix_base_addr = '0;
    bus.kernel_base_addr = '0;
    bus.result_base_addr = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.pix_rd_en, bus.kw_rd_en, bus.res_we, bus.busy, bus.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 00000",
               {bus.pix_rd_en, bus.kw_rd_en, bus.res_we, bus.busy, bus.done});
    end
    n_checks++;
    if (bus.pix_addr !== '0 || bus.kw_addr !== '0 || bus.res_addr !== '0 || bus.res_data !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got pa=%0d ka=%0d ra=%0d rd=%h, required all 0",
               bus.pix_addr, bus.kw_addr, bus.res_addr, bus.res_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.pix_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b rd=%b, required 0 0", bus.busy, bus.pix_rd_en);
    end
  endtask

  task automatic test_basic();
    int de, rc, ov;
    fill_mem(16'sd1, 16'sd1, 1'b0);
    run_layer(1'b0, 14'd0, 14'd1000, 14'd2000, 0, de, rc, ov);
    n_checks++;
    if (de !== LAYER) begin
      n_fail++;
      $display("FAIL basic_done_latency: got %0d, required %0d", de, LAYER);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_at_done: got %b, required 0", bus.busy);
    end
    n_checks++;
    if (rc !== NPIX * TAPS || ov !== 0) begin
      n_fail++;
      $display("FAIL basic_reads: got reads=%0d overlap=%0d, required %0d 0", rc, ov, NPIX * TAPS);
    end
    n_checks++;
    if (n_writes !== NPIX || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL basic_writes: got %0d left=%0d, required %0d 0", n_writes, exp_q.size(), NPIX);
    end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_done: got busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_relu();
    int de, rc, ov;
    fill_mem(16'sd2, -16'sd1, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      run_layer(pass[0], 14'd0, 14'd500, 14'd3000, 0, de, rc, ov);
      n_checks++;
      if (de !== LAYER || n_writes !== NPIX) begin
        n_fail++;
        $display("FAIL relu_pass%0d: got done=%0d writes=%0d, required %0d %0d",
                 pass, de, n_writes, LAYER, NPIX);
      end
    end
  endtask

  task automatic test_saturation();
    int de, rc, ov;
    fill_mem(16'sh0100, 16'sh0100, 1'b0);
    run_layer(1'b0, 14'd0, 14'd0, 14'd100, 0, de, rc, ov);
    fill_mem(16'sh0100, 16'shFF00, 1'b0);
    run_layer(1'b0, 14'd0, 14'd0, 14'd200, 0, de, rc, ov);
    n_checks++;
    if (n_writes !== NPIX || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL sat_writes: got %0d left=%0d, required %0d 0", n_writes, exp_q.size(), NPIX);
    end
  endtask

  task automatic test_stride_addr();
    int de, rc, ov;
    fill_mem(16'sd0, 16'sd0, 1'b1);
    run_layer(1'b0, 14'd100, 14'd700, 14'd900, 0, de, rc, ov);
    n_checks++;
    if (pix_first[3] !== 14'd112) begin
      n_fail++;
      $display("FAIL stride_pix_addr: got %0d, required 112", pix_first[3]);
    end
    n_checks++;
    if (kw_first[3] !== 14'd700) begin
      n_fail++;
      $display("FAIL stride_kw_addr: got %0d, required 700", kw_first[3]);
    end
    n_checks++;
    if (pix_first[1] !== 14'd102) begin
      n_fail++;
      $display("FAIL stride_pix_addr_col1: got %0d, required 102", pix_first[1]);
    end
  endtask

  task automatic test_start_ignored();
    int de, rc, ov;
    fill_mem(16'sd0, 16'sd0, 1'b1);
    run_layer(1'b1, 14'd40, 14'd80, 14'd120, 5, de, rc, ov);
    n_checks++;
    if (de !== LAYER || n_writes !== NPIX || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL start_ignored: got done=%0d writes=%0d left=%0d, required %0d %0d 0",
               de, n_writes, exp_q.size(), LAYER, NPIX);
    end
  endtask

  task automatic test_reset_mid();
    int de, rc, ov, done_before;
    fill_mem(16'sd3, 16'sd1, 1'b0);
    push_expected(14'd0, 14'd0, 14'd50, 1'b0);
    @(negedge clk);
    bus.relu_en = 1'b0;
    bus.pix_base_addr = 14'd0;
    bus.kernel_base_addr = 14'd0;
    bus.result_base_addr = 14'd50;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.pix_rd_en, bus.kw_rd_en, bus.busy} !== 3'b0 || bus.pix_addr !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got rd=%b kw=%b busy=%b pa=%0d, required all 0",
               bus.pix_rd_en, bus.kw_rd_en, bus.busy, bus.pix_addr);
    end
    exp_q.delete();
    n_writes = 0;
    done_before = n_done;
    repeat (100) @(negedge clk);
    n_checks++;
    if (n_writes !== 0 || n_done !== done_before) begin
      n_fail++;
      $display("FAIL reset_abandon: got writes=%0d done=%0d, required 0 0",
               n_writes, n_done - done_before);
    end
    rst_n = 1'b1;
    run_layer(1'b0, 14'd0, 14'd0, 14'd50, 0, de, rc, ov);
    n_checks++;
    if (de !== LAYER || n_writes !== NPIX) begin
      n_fail++;
      $display("FAIL restart_after_reset: got done=%0d writes=%0d, required %0d %0d",
               de, n_writes, LAYER, NPIX);
    end
  endtask

  task automatic test_back_to_back();
    int de, rc, ov, de2;
    fill_mem(16'sd0, 16'sd0, 1'b1);
    run_layer(1'b0, 14'd10, 14'd20, 14'd30, 0, de, rc, ov);
    push_expected(14'd11, 14'd21, 14'd31, 1'b0);
    bus.pix_base_addr = 14'd11;
    bus.kernel_base_addr = 14'd21;
    bus.result_base_addr = 14'd31;
    bus.relu_en = 1'b0;
    bus.start = 1'b1;
    n_writes = 0;
    @(posedge clk);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.pix_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back_accept: got busy=%b rd=%b, required 1 1", bus.busy, bus.pix_rd_en);
    end
    de2 = -1;
    for (int cyc = 2; cyc <= 4 * LAYER; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        de2 = cyc - 1;
        break;
      end
    end
    n_checks++;
    if (de2 !== LAYER || n_writes !== NPIX) begin
      n_fail++;
      $display("FAIL back_to_back_layer: got done=%0d writes=%0d, required %0d %0d",
               de2, n_writes, LAYER, NPIX);
    end
  endtask

  task automatic test_wrap();
    int de, rc, ov;
    fill_mem(16'sd0, 16'sd0, 1'b1);
    run_layer(1'b0, 14'(MEMSZ - 2), 14'(MEMSZ - 1), 14'(MEMSZ - 3), 0, de, rc, ov);
    n_checks++;
    if (rd_first3[0] !== 14'd16382 || rd_first3[1] !== 14'd16383 || rd_first3[2] !== 14'd0) begin
      n_fail++;
      $display("FAIL wrap_addr: got %0d %0d %0d, required 16382 16383 0",
               rd_first3[0], rd_first3[1], rd_first3[2]);
    end
    n_checks++;
    if (de !== LAYER || n_writes !== NPIX) begin
      n_fail++;
      $display("FAIL wrap_layer: got done=%0d writes=%0d, required %0d %0d",
               de, n_writes, LAYER, NPIX);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_stride_addr();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL leftover_expected: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
